// File: rtl/urt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : urt_pkg
//  Description : Shared definitions for the UART receive controller: state
//                encoding constants, the state enum and the 2-of-3 majority
//                helper used by the bit sampler.
//                Optional feature macro: URT_RX_BREAK_EN (adds BRK_WAIT).
//  Revision    : 1.0 - initial release
// ============================================================================
package urt_pkg;

    // State encoding constants (3 bits wide)
    localparam logic [2:0] URT_RX_ST_IDLE     = 3'd0;
    localparam logic [2:0] URT_RX_ST_START    = 3'd1;
    localparam logic [2:0] URT_RX_ST_DATA     = 3'd2;
    localparam logic [2:0] URT_RX_ST_PARITY   = 3'd3;
    localparam logic [2:0] URT_RX_ST_STOP     = 3'd4;
    localparam logic [2:0] URT_RX_ST_ERR_CHK  = 3'd5;
    localparam logic [2:0] URT_RX_ST_VALID    = 3'd6;
`ifdef URT_RX_BREAK_EN
    localparam logic [2:0] URT_RX_ST_BRK_WAIT = 3'd7;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = URT_RX_ST_IDLE,
        ST_START    = URT_RX_ST_START,
        ST_DATA     = URT_RX_ST_DATA,
        ST_PARITY   = URT_RX_ST_PARITY,
        ST_STOP     = URT_RX_ST_STOP,
        ST_ERR_CHK  = URT_RX_ST_ERR_CHK,
`ifdef URT_RX_BREAK_EN
        ST_VALID    = URT_RX_ST_VALID,
        ST_BRK_WAIT = URT_RX_ST_BRK_WAIT
`else
        ST_VALID    = URT_RX_ST_VALID
`endif
    } urt_rx_state_e;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/urt_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : urt_rx_sampler
//  Description : Captures RX at the three mid-bit edge counts
//                (PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1) and presents the
//                majority-decided bit together with a strobe on the last
//                edge count of the bit period.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_en            - bit timing active (counting state)
//                i_rx            - serial line
//                i_edge_cnt      - edge counter 0..PRESCALE-1
//                o_bit           - decided bit value
//                o_bit_done      - high on edge count PRESCALE-1 when enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module urt_rx_sampler
    import urt_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_rx,
    input  logic [CNT_W-1:0] i_edge_cnt,
    output logic             o_bit,
    output logic             o_bit_done
);

    localparam logic [CNT_W-1:0] c_S0   = CNT_W'(PRESCALE/2 - 1);
    localparam logic [CNT_W-1:0] c_S1   = CNT_W'(PRESCALE/2);
    localparam logic [CNT_W-1:0] c_S2   = CNT_W'(PRESCALE/2 + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PRESCALE - 1);

    logic [2:0] r_smp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp <= 3'b000;
        end else if (i_en) begin
            if (i_edge_cnt == c_S0) r_smp[0] <= i_rx;
            if (i_edge_cnt == c_S1) r_smp[1] <= i_rx;
            if (i_edge_cnt == c_S2) r_smp[2] <= i_rx;
        end
    end

    // All three samples are settled well before the last edge count, so the
    // decision is purely registered and has no combinational path from RX.
    assign o_bit      = maj3(r_smp[0], r_smp[1], r_smp[2]);
    assign o_bit_done = i_en && (i_edge_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/urt_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : urt_rx_ctrl
//  Description : UART receive controller. Oversampled (PRESCALE clocks per
//                bit) frame reception with majority-vote bit decisions,
//                optional parity, one or two stop bits and one-cycle status
//                pulses. Optional break detection via macro URT_RX_BREAK_EN.
//  Ports       : CLK, RST      - clock, synchronous active-high reset
//                RX_IN         - serial line, idle high, pre-synchronised
//                PAR_EN        - parity bit present
//                PAR_TYP       - 0 even / 1 odd parity
//                STOP2         - two stop bits
//                P_DATA        - received word, held until next VALID
//                data_valid    - one-cycle pulse, P_DATA valid
//                par_err       - one-cycle parity error pulse
//                stp_err       - one-cycle stop error pulse
//                strt_glitch   - one-cycle false start pulse
//                brk_det       - one-cycle break pulse (0 unless enabled)
//  Revision    : 1.0 - initial release
// ============================================================================
module urt_rx_ctrl
    import urt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  brk_det
);

    localparam int c_CNT_W = $clog2(PRESCALE);
    localparam int c_BIT_W = 4;  // frame index never exceeds 13
    localparam logic [c_CNT_W-1:0] c_EDGE_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_WIDTH);

    urt_rx_state_e          r_state, w_next;
    logic [c_CNT_W-1:0]     r_edge_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic                   r_par_en, r_par_typ, r_stop2;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  r_p_data;
    logic                   r_par_flag, r_stp_flag;

    logic                   w_cnt_en;
    logic                   w_bit, w_bit_done;
    logic                   w_frame_start;
    logic [c_BIT_W-1:0]     w_last_idx;

    // Bit index 0 is the start bit, data bits are 1..DATA_WIDTH, then the
    // optional parity bit, then the stop bit(s).
    assign w_last_idx = c_BIT_W'(DATA_WIDTH + 1) + c_BIT_W'(r_par_en)
                      + c_BIT_W'(r_stop2);

    assign w_frame_start = (w_next == ST_START) && (r_state != ST_START);

    always_comb begin
        w_cnt_en = 1'b0;
        case (r_state)
            ST_START, ST_DATA, ST_PARITY, ST_STOP: w_cnt_en = 1'b1;
`ifdef URT_RX_BREAK_EN
            ST_BRK_WAIT:                           w_cnt_en = 1'b1;
`endif
            default:                               w_cnt_en = 1'b0;
        endcase
    end

    urt_rx_sampler #(
        .PRESCALE (PRESCALE),
        .CNT_W    (c_CNT_W)
    ) u_sampler (
        .clk        (CLK),
        .rst        (RST),
        .i_en       (w_cnt_en),
        .i_rx       (RX_IN),
        .i_edge_cnt (r_edge_cnt),
        .o_bit      (w_bit),
        .o_bit_done (w_bit_done)
    );

`ifdef URT_RX_BREAK_EN
    // Break tracking: all data/parity bits zero and the first stop bit zero.
    logic               r_all_zero;
    logic               r_stop0_low;
    logic               w_brk;
    logic               w_brk_det;
    logic [c_BIT_W-1:0] w_first_stop;

    assign w_first_stop = c_BIT_W'(DATA_WIDTH + 1) + c_BIT_W'(r_par_en);
    assign w_brk        = r_all_zero & r_stop0_low;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_all_zero  <= 1'b0;
            r_stop0_low <= 1'b0;
        end else if (w_frame_start) begin
            r_all_zero  <= 1'b1;
            r_stop0_low <= 1'b0;
        end else if (w_bit_done) begin
            if ((r_state == ST_DATA || r_state == ST_PARITY) && w_bit)
                r_all_zero <= 1'b0;
            if (r_state == ST_STOP && r_bit_cnt == w_first_stop && !w_bit)
                r_stop0_low <= 1'b1;
        end
    end

    assign brk_det = w_brk_det;
`else
    assign brk_det = 1'b0;
`endif

    // Next-state and pulse outputs
    always_comb begin
        w_next      = r_state;
        data_valid  = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        strt_glitch = 1'b0;
`ifdef URT_RX_BREAK_EN
        w_brk_det   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN) w_next = ST_START;
            end
            ST_START: begin
                if (w_bit_done) begin
                    if (w_bit) begin
                        strt_glitch = 1'b1;
                        w_next      = ST_IDLE;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_bit_done && r_bit_cnt == c_DATA_LAST)
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_done) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_done && r_bit_cnt == w_last_idx) w_next = ST_ERR_CHK;
            end
            ST_ERR_CHK: begin
`ifdef URT_RX_BREAK_EN
                if (w_brk) begin
                    w_brk_det = 1'b1;
                    w_next    = ST_BRK_WAIT;
                end else
`endif
                begin
                    par_err = r_par_flag;
                    stp_err = r_stp_flag;
                    w_next  = (r_par_flag || r_stp_flag) ? ST_IDLE : ST_VALID;
                end
            end
            ST_VALID: begin
                data_valid = 1'b1;
                w_next     = RX_IN ? ST_IDLE : ST_START;
            end
`ifdef URT_RX_BREAK_EN
            ST_BRK_WAIT: begin
                if (w_bit_done && w_bit) w_next = ST_IDLE;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_shift    <= '0;
            r_p_data   <= '0;
            r_par_flag <= 1'b0;
            r_stp_flag <= 1'b0;
        end else begin
            r_state <= w_next;

            // Counters run only in bit-timed states and sit at zero elsewhere,
            // so every entry to START (from IDLE or VALID) begins at 0/0.
            if (w_cnt_en) begin
                if (r_edge_cnt == c_EDGE_LAST) begin
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end else begin
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                end
            end else begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= '0;
            end

            if (w_frame_start) begin
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_stop2    <= STOP2;
                r_par_flag <= 1'b0;
                r_stp_flag <= 1'b0;
            end

            if (r_state == ST_DATA && w_bit_done)
                r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};

            if (r_state == ST_PARITY && w_bit_done
                && (w_bit != ((^r_shift) ^ r_par_typ)))
                r_par_flag <= 1'b1;

            if (r_state == ST_STOP && w_bit_done && !w_bit)
                r_stp_flag <= 1'b1;

            // Load on the way into VALID so P_DATA is current during VALID.
            if (w_next == ST_VALID)
                r_p_data <= r_shift;
        end
    end

    assign P_DATA = r_p_data;

endmodule
`default_nettype wire

// File: tb/tb_urt_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_urt_rx_ctrl
//  Description : Directed self-checking bench for urt_rx_ctrl
//                (DATA_WIDTH=8, PRESCALE=8, default build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_urt_rx_ctrl;

    localparam int c_W = 8;
    localparam int c_P = 8;

    logic           CLK     = 1'b0;
    logic           RST     = 1'b1;
    logic           RX_IN   = 1'b1;
    logic           PAR_EN  = 1'b0;
    logic           PAR_TYP = 1'b0;
    logic           STOP2   = 1'b0;
    logic [c_W-1:0] P_DATA;
    logic           data_valid, par_err, stp_err, strt_glitch, brk_det;

    int cyc = 0;
    int t0  = 0;
    int n_chk = 0, n_pass = 0;

    // monitor totals (written only by the monitor)
    int n_dv = 0, n_pe = 0, n_se = 0, n_gl = 0, n_bk = 0, n_ovl = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0, gl_cyc = 0;
    int dv_data = 0, dv_prev = 0;
    // snapshots taken at the start of each test
    int b_dv, b_pe, b_se, b_gl, b_bk;

    logic [15:0] frame_bits;

    urt_rx_ctrl #(
        .DATA_WIDTH (c_W),
        .PRESCALE   (c_P)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .STOP2       (STOP2),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch),
        .brk_det     (brk_det)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (data_valid) begin
                n_dv++; dv_prev = dv_data; dv_data = int'(P_DATA); dv_cyc = cyc;
            end
            if (par_err)     begin n_pe++; pe_cyc = cyc; end
            if (stp_err)     begin n_se++; se_cyc = cyc; end
            if (strt_glitch) begin n_gl++; gl_cyc = cyc; end
            if (brk_det)     n_bk++;
            if (data_valid && (par_err || stp_err || strt_glitch || brk_det)) n_ovl++;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, act, act, exp, exp);
    endtask

    task automatic snap();
        b_dv = n_dv; b_pe = n_pe; b_se = n_se; b_gl = n_gl; b_bk = n_bk;
    endtask

    // Called at a negedge; each bit is held for c_P rising edges, LSB first.
    task automatic send_bits(input logic [15:0] b, input int n);
        t0 = cyc + 1;
        for (int i = 0; i < n; i++) begin
            RX_IN = b[i];
            repeat (c_P) @(negedge CLK);
        end
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge CLK);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_p_data",     int'(P_DATA),     0);
        chk("rst_par_err",    int'(par_err),    0);
        chk("rst_stp_err",    int'(stp_err),    0);
        chk("rst_glitch",     int'(strt_glitch), 0);
        chk("rst_brk_det",    int'(brk_det),    0);
        RST = 1'b0;
        idle(4);

        // ---------------- 0xA5, no parity, one stop ----------------
        snap();
        frame_bits = {6'b0, 1'b1, 8'hA5, 1'b0};
        send_bits(frame_bits, 10);
        idle(20);
        chk("a5_dv_count", n_dv - b_dv, 1);
        chk("a5_dv_cycle", dv_cyc - t0, 81);
        chk("a5_data",     dv_data, 'hA5);
        chk("a5_no_err",   (n_pe - b_pe) + (n_se - b_se) + (n_gl - b_gl) + (n_bk - b_bk), 0);

        // ---------------- even parity, 0x0F with wrong parity 1 ----------------
        snap();
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        frame_bits = {5'b0, 1'b1, 1'b1, 8'h0F, 1'b0};
        send_bits(frame_bits, 11);
        idle(20);
        chk("pe_count",      n_pe - b_pe, 1);
        chk("pe_cycle",      pe_cyc - t0, 88);
        chk("pe_no_dv",      n_dv - b_dv, 0);
        chk("pe_pdata_held", int'(P_DATA), 'hA5);

        // ---------------- odd parity correct, config changed mid-frame ----------------
        snap();
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        fork
            send_bits(frame_bits, 11);
            begin
                idle(20);
                PAR_EN = 1'b0; PAR_TYP = 1'b0;
            end
        join
        idle(20);
        chk("odd_dv_cycle", dv_cyc - t0, 89);
        chk("odd_data",     dv_data, 'h0F);
        chk("odd_no_pe",    n_pe - b_pe, 0);

        // ---------------- start glitch: 3 low cycles ----------------
        snap();
        t0 = cyc + 1;
        RX_IN = 1'b0;
        idle(3);
        RX_IN = 1'b1;
        idle(20);
        chk("gl_count", n_gl - b_gl, 1);
        chk("gl_cycle", gl_cyc - t0, 7);
        chk("gl_no_dv", n_dv - b_dv, 0);

        // ---------------- two stop bits, second stop bit 0 ----------------
        snap();
        STOP2 = 1'b1;
        frame_bits = {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
        send_bits(frame_bits, 11);
        idle(20);
        chk("stp2_count", n_se - b_se, 1);
        chk("stp2_cycle", se_cyc - t0, 88);
        chk("stp2_no_dv", n_dv - b_dv, 0);
        STOP2 = 1'b0;

        // ---------------- back-to-back frames 0x3C, 0xC3 ----------------
        snap();
        frame_bits = {6'b0, 1'b1, 8'h3C, 1'b0};
        send_bits(frame_bits, 10);
        frame_bits = {6'b0, 1'b1, 8'hC3, 1'b0};
        send_bits(frame_bits, 10);
        idle(20);
        chk("b2b_dv_count", n_dv - b_dv, 2);
        chk("b2b_first",    dv_prev, 'h3C);
        chk("b2b_second",   dv_data, 'hC3);
        chk("b2b_cycle2",   dv_cyc - t0, 83);

        // ---------------- line low for 20 bit times (break disabled) ----------------
        snap();
        t0 = cyc + 1;
        RX_IN = 1'b0;
        idle(20 * c_P);
        RX_IN = 1'b1;
        idle(30);
        chk("brk_stp_count", n_se - b_se, 2);
        chk("brk_last_stp",  se_cyc - t0, 162);
        chk("brk_no_brkdet", n_bk - b_bk, 0);
        chk("brk_no_dv",     n_dv - b_dv, 0);

        // ---------------- reset at cycle 40 of a 0x55 frame ----------------
        snap();
        PAR_EN = 1'b0;
        frame_bits = {6'b0, 1'b1, 8'h55, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            RX_IN = frame_bits[i];
            idle(c_P);
        end
        idle(1);
        RST = 1'b1; RX_IN = 1'b1;
        idle(1);
        chk("mrst_p_data", int'(P_DATA), 0);
        chk("mrst_pulses", int'({data_valid, par_err, stp_err, strt_glitch, brk_det}), 0);
        idle(1);
        RST = 1'b0;
        idle(30);
        chk("mrst_no_pulse", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se)
                             + (n_gl - b_gl) + (n_bk - b_bk), 0);
        snap();
        send_bits(frame_bits, 10);
        idle(20);
        chk("post_rst_dv_count", n_dv - b_dv, 1);
        chk("post_rst_dv_cycle", dv_cyc - t0, 81);
        chk("post_rst_data",     dv_data, 'h55);

        chk("no_overlap", n_ovl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
